// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB first, one bit per clock.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    logic sum_bit_d;
    logic carry_d;
    logic last_bit;

    // The single full-adder slice operating on the current LSBs.
    always_comb begin
        sum_bit_d = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        last_bit  = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= Cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    s_q     <= {sum_bit_d, s_q[WIDTH-1:1]};
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    // Cout (and ovf) update together with the final sum bit so they stay valid with S.
                    if (last_bit) begin
                        cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q   <= carry_q ^ carry_d;
`endif
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random self-checking bench for serial_adder (WIDTH=8).
// Define SERIAL_ADDER_OVF_EN for both bench and RTL to also check ovf.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       busy;
    logic       done;
    logic [7:0] S;
    logic       Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .busy (busy),
        .done (done),
        .S    (S),
        .Cout (Cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One addition: start for one cycle, optionally zero the operands during SHIFT,
    // wait (bounded) for done and report latency and busy cycles.
    task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input bit scramble, output logic [7:0] s_out, output logic co_out,
                          output logic ov_out, output int lat, output int busy_n);
        @(negedge clk);
        A = a; B = b; Cin = cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            A = 8'h00; B = 8'h00; Cin = 1'b0;
        end
        lat    = 1;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) check("done_timeout", 64'(lat), 64'd9);
        if (busy) busy_n++;
        s_out  = S;
        co_out = Cout;
`ifdef SERIAL_ADDER_OVF_EN
        ov_out = ovf;
`else
        ov_out = 1'b0;
`endif
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("idle_after_done", {63'd0, busy}, 64'd0);
        $display("op A=%02h B=%02h Cin=%0d -> S=%02h Cout=%0d lat=%0d busy=%0d",
                 a, b, cin, s_out, co_out, lat, busy_n);
    endtask

    task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input bit scramble,
                            input logic [7:0] exp_s, input logic exp_c);
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         lat;
        int         bn;
        logic [8:0] full;
        logic       exp_ov;
        do_add(a, b, cin, scramble, s, co, ov, lat, bn);
        check({tag, "_S"}, 64'(s), 64'(exp_s));
        check({tag, "_Cout"}, 64'(co), 64'(exp_c));
        check({tag, "_lat"}, 64'(lat), 64'd9);
        check({tag, "_busy"}, 64'(bn), 64'd9);
        full   = 9'(a) + 9'(b) + 9'(cin);
        exp_ov = (a[7] == b[7]) && (full[7] != a[7]);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 64'(ov), 64'(exp_ov));
`else
        if (ov !== 1'b0 && exp_ov === 1'b0) check({tag, "_ovf_absent"}, 64'(ov), 64'd0);
`endif
    endtask

    initial begin
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         lat;
        int         bn;
        int         last_t;
        int         n_done;
        logic [31:0] r;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rc;
        logic [8:0]  full;

        rst_n = 1'b0; start = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_S", 64'(S), 64'd0);
        check("rst_Cout", {63'd0, Cout}, 64'd0);
        rst_n = 1'b1;

        directed("zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        directed("ff_p1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        directed("7f_p1", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0);

        // Result must hold through idle cycles.
        repeat (3) @(negedge clk);
        check("hold_S", 64'(S), 64'h80);
        check("hold_Cout", {63'd0, Cout}, 64'd0);

        directed("a5_5a_scr", 8'hA5, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1);

        // start held high: one result every 10 cycles, never restarted while busy.
        @(negedge clk);
        A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
        last_t = -1;
        n_done = 0;
        for (int t = 0; t < 40 && n_done < 3; t++) begin
            @(negedge clk);
            if (done) begin
                check("cont_S", 64'(S), 64'h46);
                if (last_t >= 0) check("cont_period", 64'(t - last_t), 64'd10);
                $display("cont done at t=%0d S=%02h", t, S);
                last_t = t;
                n_done++;
            end
        end
        start = 1'b0;
        check("cont_count", 64'(n_done), 64'd3);
        repeat (2) @(negedge clk);

        // Reset in the 4th SHIFT cycle.
        A = 8'hF0; B = 8'h0F; Cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_S", 64'(S), 64'd0);
        check("midrst_Cout", {63'd0, Cout}, 64'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            check("midrst_no_done", {63'd0, done}, 64'd0);
        end
        $display("reset mid-operation applied and released");
        directed("after_rst", 8'h03, 8'h04, 1'b1, 1'b0, 8'h08, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            r  = $urandom;
            ra = r[7:0];
            rb = r[15:8];
            rc = r[16];
            full = 9'(ra) + 9'(rb) + 9'(rc);
            do_add(ra, rb, rc, r[17], s, co, ov, lat, bn);
            check("rand_sum", 64'({co, s}), 64'(full));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter WIDTH SHALL default to 8 and set the operand width in bits; legal range 2..32.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-006 Port A  input  WIDTH  operand A; captured when start is accepted.
REQ-007 Port B  input  WIDTH  operand B; captured when start is accepted.
REQ-008 Port Cin  input  1  carry-in; captured when start is accepted.
REQ-009 Port busy  output  1  high while an addition is in progress.
REQ-010 Port done  output  1  one-cycle pulse when S and Cout are valid.
REQ-011 Port S  output  WIDTH  sum, valid from done until the next accepted start.
REQ-012 Port Cout  output  1  final carry-out, valid with S.

Function
REQ-013 The block SHALL be a bit-serial adder: one internal 1-bit full-adder slice and one carry flip-flop, processing operands LSB first, one bit per clock.
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-015 IDLE: when start=1, the block SHALL load the A and B shift registers, load the carry flip-flop with Cin, clear the bit counter, and enter SHIFT on the next edge.
REQ-016 SHIFT: on each edge, the block SHALL compute sum bit = a0^b0^c and carry = a0&b0 | c&(a0^b0), shift the sum bit into the MSB of the S register (right shift), shift A and B right by one, and increment the counter.
REQ-017 After exactly WIDTH SHIFT cycles, the block SHALL enter DONE; S SHALL hold the full sum and Cout SHALL hold the final carry.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 Latency from the edge that accepts start to done=1 SHALL be WIDTH+1 cycles.
REQ-020 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-021 start SHALL be ignored while busy=1; a start asserted in the DONE cycle SHALL NOT be accepted.
REQ-022 A start asserted in the IDLE cycle that directly follows DONE SHALL be accepted, which gives back-to-back operations one IDLE cycle apart.
REQ-023 A, B and Cin SHALL be don't-care except on the accepting edge; changes during SHIFT SHALL NOT affect the result.
REQ-024 Wrap-around: the result SHALL equal (A+B+Cin) mod 2^WIDTH, with Cout equal to bit WIDTH of the exact sum.
REQ-025 S and Cout SHALL hold their last values in IDLE until the next accepted start; S SHALL change only in SHIFT.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, S=0, Cout=0, and the counter, carry and shift registers to 0.
REQ-027 Reset asserted mid-operation SHALL abort the addition with no done pulse; the first accepted start after reset is released SHALL produce a correct result.

Configuration
REQ-028 Macro SERIAL_ADDER_OVF_EN SHALL control a signed-overflow output.
REQ-029 With SERIAL_ADDER_OVF_EN defined, the block SHALL add port ovf  output  1, equal to the carry into the MSB XOR Cout. It SHALL be registered with S, set to 0 on reset, and valid with done.
REQ-030 Without SERIAL_ADDER_OVF_EN defined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-031 A=0x00, B=0x00, Cin=0, start for one cycle -> done after 9 cycles; S=0x00, Cout=0; busy high for 9 cycles.
REQ-032 A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1. With the macro defined, ovf=0 for this case. A=0x7F, B=0x01 -> S=0x80, ovf=1.
REQ-033 A=0xA5, B=0x5A, Cin=1 -> S=0x00, Cout=1. Operands are changed to 0x00 during SHIFT, and the result SHALL be unchanged.
REQ-034 start held high continuously with A=0x12, B=0x34 -> done every 10 cycles, S=0x46 each time. Starts during busy SHALL NOT restart the operation.
REQ-035 rst_n pulled low at the 4th SHIFT cycle -> outputs zero at once and no done pulse. A new start with A=0x03, B=0x04, Cin=1 after reset -> S=0x08, Cout=0.
REQ-036 1000 random A, B, Cin -> {Cout,S} SHALL equal A+B+Cin for every operation.
